// File: rtl/event_readout_ctrl.sv
// Acquisition sequencer: arm, trigger edge, post-trigger delay, snapshot latch,
// valid/ready serial readout of the frozen channel words, then holdoff.
`timescale 1ns/1ps
module event_readout_ctrl #(
    parameter int unsigned N_CH      = 16,
    parameter int unsigned WORD_W    = 64,
    parameter int unsigned POST_TRIG = 32,
    parameter int unsigned HOLDOFF   = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                           clk_500,
    input  logic                           rst,
    input  logic                           arm,
    input  logic                           trig_tresh,
    input  logic [N_CH-1:0][WORD_W-1:0]    evento,
    output logic                           event_saved,
    output logic                           busy,
    output logic [WORD_W-1:0]              dout_data,
    output logic [$clog2(N_CH)-1:0]        dout_ch,
    output logic                           dout_valid,
    input  logic                           dout_ready,
    output logic                           dout_last,
    output logic [CNT_W-1:0]               event_count,
    output logic [CNT_W-1:0]               missed_count
);

    localparam int unsigned CH_W    = $clog2(N_CH);
    localparam int unsigned TMR_MAX = (POST_TRIG > HOLDOFF) ? POST_TRIG : HOLDOFF;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARMED, S_POST, S_LATCH, S_READ, S_HOLD
    } state_e;

    state_e                       state_q, state_d;
    logic [TMR_W-1:0]             cnt_q, cnt_d;
    logic [CH_W-1:0]              idx_q, idx_d;
    logic [N_CH-1:0][WORD_W-1:0]  shadow_q, shadow_d;
    logic                         trig_q, trig_d;
    logic [CNT_W-1:0]             event_count_q, event_count_d;
    logic [CNT_W-1:0]             missed_count_q, missed_count_d;
    logic                         event_saved_q, event_saved_d;
    logic                         busy_q, busy_d;
    logic                         dout_valid_q, dout_valid_d;
    logic                         dout_last_q, dout_last_d;
    logic [WORD_W-1:0]            dout_data_q, dout_data_d;
    logic [CH_W-1:0]              dout_ch_q, dout_ch_d;

    logic trig_edge;
    logic accept;

    assign trig_edge = trig_tresh & ~trig_q;
    assign accept    = dout_valid_q & dout_ready;
    assign trig_d    = trig_tresh;

    // Sequencer next state, counters, and output registers derived from the next state
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        idx_d          = idx_q;
        shadow_d       = shadow_q;
        event_count_d  = event_count_q;
        missed_count_d = missed_count_q;

        case (state_q)
            S_IDLE: begin
                if (arm) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (!arm) begin
                    state_d = S_IDLE;
                end else if (trig_edge) begin
                    state_d = S_POST;
                    cnt_d   = TMR_W'(POST_TRIG - 1);
                end
            end
            S_POST: begin
                if (cnt_q == '0) state_d = S_LATCH;
                else             cnt_d   = cnt_q - TMR_W'(1);
            end
            S_LATCH: begin
                shadow_d = evento;
                idx_d    = '0;
                state_d  = S_READ;
            end
            S_READ: begin
                if (accept) begin
                    if (idx_q != CH_W'(N_CH - 1)) begin
                        idx_d = idx_q + CH_W'(1);
                    end else begin
                        if (event_count_q != {CNT_W{1'b1}})
                            event_count_d = event_count_q + CNT_W'(1);
                        cnt_d   = TMR_W'(HOLDOFF - 1);
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) state_d = arm ? S_ARMED : S_IDLE;
                else             cnt_d   = cnt_q - TMR_W'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // Edges arriving mid-sequence are only counted, never restart the sequence
        if (trig_edge && (state_q inside {S_POST, S_LATCH, S_READ, S_HOLD}) &&
            (missed_count_q != {CNT_W{1'b1}}))
            missed_count_d = missed_count_q + CNT_W'(1);

        event_saved_d = (state_d == S_LATCH);
        busy_d        = !(state_d inside {S_IDLE, S_ARMED});
        dout_valid_d  = (state_d == S_READ);
        dout_ch_d     = dout_valid_d ? idx_d : '0;
        dout_data_d   = dout_valid_d ? shadow_d[idx_d] : '0;
        dout_last_d   = dout_valid_d && (idx_d == CH_W'(N_CH - 1));
    end

    always_ff @(posedge clk_500) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            idx_q          <= '0;
            shadow_q       <= '0;
            trig_q         <= 1'b0;
            event_count_q  <= '0;
            missed_count_q <= '0;
            event_saved_q  <= 1'b0;
            busy_q         <= 1'b0;
            dout_valid_q   <= 1'b0;
            dout_last_q    <= 1'b0;
            dout_data_q    <= '0;
            dout_ch_q      <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            idx_q          <= idx_d;
            shadow_q       <= shadow_d;
            trig_q         <= trig_d;
            event_count_q  <= event_count_d;
            missed_count_q <= missed_count_d;
            event_saved_q  <= event_saved_d;
            busy_q         <= busy_d;
            dout_valid_q   <= dout_valid_d;
            dout_last_q    <= dout_last_d;
            dout_data_q    <= dout_data_d;
            dout_ch_q      <= dout_ch_d;
        end
    end

    assign event_saved  = event_saved_q;
    assign busy         = busy_q;
    assign dout_valid   = dout_valid_q;
    assign dout_last    = dout_last_q;
    assign dout_data    = dout_data_q;
    assign dout_ch      = dout_ch_q;
    assign event_count  = event_count_q;
    assign missed_count = missed_count_q;

endmodule
